// File: rtl/rv_pkg.sv
// Shared definitions for the control-transfer sequencers of the single-issue core.
package rv_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [2:0] FUNCT3_JALR = 3'b000;

  localparam logic IMM_SEL_I = 1'b0;
  localparam logic IMM_SEL_J = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_REDIRECT,
    ST_FLUSH,
    ST_LINK
  } jr_state_e;

  function automatic logic is_jal(input logic [31:0] w);
    return w[6:0] == OP_JAL;
  endfunction

  function automatic logic is_jalr(input logic [31:0] w);
    return (w[6:0] == OP_JALR) && (w[14:12] == FUNCT3_JALR);
  endfunction

endpackage

// File: rtl/rv_imm_extend.sv
// Combinational J-type / I-type immediate reassembly with sign extension.
module rv_imm_extend
  import rv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [31:0]     instr,
  input  logic            imm_sel,
  output logic [XLEN-1:0] imm
);

  logic unused_low_bits;
  assign unused_low_bits = ^instr[11:0];

  always_comb begin
    if (imm_sel == IMM_SEL_J)
      imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    else
      imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
  end

endmodule

// File: rtl/jump_redirect_ctrl.sv
// JAL/JALR sequencer: computes the target, redirects fetch, flushes, then writes the link.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | ready for decode; non-jumps are consumed and dropped
// ST_CALC     | register target, rd and link value; detect misalignment
// ST_REDIRECT | present redir_pc until fetch accepts
// ST_FLUSH    | hold flush for FLUSH_CYCLES cycles
// ST_LINK     | present link writeback until granted (skipped for rd == x0)
module jump_redirect_ctrl
  import rv_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr_word,
  input  logic [XLEN-1:0] instr_pc,
  input  logic [XLEN-1:0] rs1_data,
  output logic            redir_valid,
  input  logic            redir_ready,
  output logic [XLEN-1:0] redir_pc,
  output logic            flush,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            misalign_err,
  output logic            busy
);

  jr_state_e       state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] target_q, target_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            misalign_q, misalign_d;

  logic            jal_q;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] calc_target;

  assign jal_q = instr_q[6:0] == OP_JAL;

  rv_imm_extend #(.XLEN(XLEN)) u_imm (
    .instr   (instr_q),
    .imm_sel (jal_q ? IMM_SEL_J : IMM_SEL_I),
    .imm     (imm)
  );

  // JALR clears bit 0 of the sum; JAL targets are always even already.
  assign sum         = (jal_q ? pc_q : rs1_q) + imm;
  assign calc_target = jal_q ? sum : {sum[XLEN-1:1], 1'b0};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      instr_q    <= '0;
      pc_q       <= '0;
      rs1_q      <= '0;
      target_q   <= '0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      rs1_q      <= rs1_d;
      target_q   <= target_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    rs1_d      = rs1_q;
    target_d   = target_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    misalign_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          instr_d = instr_word;
          pc_d    = instr_pc;
          rs1_d   = rs1_data;
          if (is_jal(instr_word) || is_jalr(instr_word))
            state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        target_d  = calc_target;
        wb_rd_d   = instr_q[11:7];
        wb_data_d = pc_q + XLEN'(4);
        if (calc_target[1:0] != 2'b00) begin
          misalign_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_REDIRECT;
        end
      end
      ST_REDIRECT: begin
        if (redir_ready) begin
          cnt_d   = 4'(FLUSH_CYCLES);
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1)
          state_d = (wb_rd_q != 5'd0) ? ST_LINK : ST_IDLE;
      end
      ST_LINK: begin
        if (wb_ready)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign instr_ready  = state_q == ST_IDLE;
  assign busy         = state_q != ST_IDLE;
  assign redir_valid  = state_q == ST_REDIRECT;
  assign flush        = state_q == ST_FLUSH;
  assign wb_valid     = state_q == ST_LINK;
  assign redir_pc     = target_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_jump_redirect_ctrl.sv
// Scoreboard bench for jump_redirect_ctrl: directed jumps, backpressure, misalignment, reset abort.
module tb_jump_redirect_ctrl;

  localparam int K_REDIR = 0;
  localparam int K_FLUSH = 1;
  localparam int K_WB    = 2;
  localparam int K_MIS   = 3;

  typedef struct {
    int          kind;
    logic [4:0]  rd;
    logic [31:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_word;
  logic [31:0] instr_pc;
  logic [31:0] rs1_data;
  logic        redir_valid;
  logic        redir_ready;
  logic [31:0] redir_pc;
  logic        flush;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign_err;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;
  ev_t exp_q[$];

  jump_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_word   (instr_word),
    .instr_pc     (instr_pc),
    .rs1_data     (rs1_data),
    .redir_valid  (redir_valid),
    .redir_ready  (redir_ready),
    .redir_pc     (redir_pc),
    .flush        (flush),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .misalign_err (misalign_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input logic [4:0] rd, input logic [31:0] data);
    ev_t e;
    e.kind = kind;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic got(input int kind, input logic [4:0] rd, input logic [31:0] data);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d data %h, expected no event at %0t", kind, data, $time);
    end else begin
      e = exp_q.pop_front();
      chk("ev_kind", 32'(kind), 32'(e.kind));
      chk("ev_data", data, e.data);
      chk("ev_rd", 32'(rd), 32'(e.rd));
    end
  endtask

  // Monitor: turns DUT outputs into events and checks hold/mutex rules.
  int          flush_run = 0;
  logic        redir_wait = 1'b0, wb_wait = 1'b0;
  logic [31:0] redir_hold, wb_hold;
  logic [4:0]  rd_hold;

  always @(negedge clk) begin
    if (flush) flush_run++;
    else if (flush_run > 0) begin
      got(K_FLUSH, 5'd0, 32'(flush_run));
      flush_run = 0;
    end
    if (redir_valid && redir_ready) got(K_REDIR, 5'd0, redir_pc);
    if (wb_valid && wb_ready) got(K_WB, wb_rd, wb_data);
    if (misalign_err) got(K_MIS, 5'd0, 32'd0);
    if (rst_n && redir_wait) begin
      chk("redir_hold_valid", 32'(redir_valid), 32'd1);
      chk("redir_hold_pc", redir_pc, redir_hold);
    end
    if (rst_n && wb_wait) begin
      chk("wb_hold_valid", 32'(wb_valid), 32'd1);
      chk("wb_hold_data", wb_data, wb_hold);
      chk("wb_hold_rd", 32'(wb_rd), 32'(rd_hold));
    end
    if (redir_valid || flush || wb_valid)
      chk("mutex", 32'(int'(redir_valid) + int'(flush) + int'(wb_valid)), 32'd1);
    redir_wait = rst_n && redir_valid && !redir_ready;
    wb_wait    = rst_n && wb_valid && !wb_ready;
    redir_hold = redir_pc;
    wb_hold    = wb_data;
    rd_hold    = wb_rd;
  end

  function automatic logic pick(input int sel);
    case (sel)
      0: return redir_valid;
      1: return flush;
      2: return wb_valid;
      3: return instr_ready && !busy;
      default: return !flush;
    endcase
  endfunction

  task automatic wait_hi(input string name, input int sel);
    int n = 0;
    while (!pick(sel) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout_%s: condition still low, expected high within 200 cycles", name);
    end
  endtask

  task automatic send(input logic [31:0] w, input logic [31:0] pc, input logic [31:0] rs1);
    wait_hi("accept", 3);
    instr_valid = 1'b1;
    instr_word  = w;
    instr_pc    = pc;
    rs1_data    = rs1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr_word  = '0;
  endtask

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr_word  = '0;
    instr_pc    = '0;
    rs1_data    = '0;
    redir_ready = 1'b1;
    wb_ready    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_instr_ready", 32'(instr_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_redir_valid", 32'(redir_valid), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    chk("rst_redir_pc", redir_pc, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // jal x1,8 at 0x100
    push(K_REDIR, 5'd0, 32'h108);
    push(K_FLUSH, 5'd0, 32'd2);
    push(K_WB, 5'd1, 32'h104);
    send(32'h008000EF, 32'h100, 32'h0);
    chk("calc_busy", 32'(busy), 32'd1);
    chk("calc_no_redir", 32'(redir_valid), 32'd0);
    @(posedge clk); #1;
    chk("jal_latency", 32'(redir_valid), 32'd1);
    chk("jal_redir_pc", redir_pc, 32'h108);
    wait_hi("idle1", 3);

    // jal x0,-4 at 0x200: no link, busy drops right after flush
    push(K_REDIR, 5'd0, 32'h1FC);
    push(K_FLUSH, 5'd0, 32'd2);
    send(32'hFFDFF06F, 32'h200, 32'h0);
    wait_hi("flush2", 1);
    wait_hi("flush2_end", 4);
    chk("x0_busy_after_flush", 32'(busy), 32'd0);
    chk("x0_no_wb", 32'(wb_valid), 32'd0);
    chk("x0_instr_ready", 32'(instr_ready), 32'd1);

    // jalr x5,0(x6) with rs1=0x1001 at 0x40
    push(K_REDIR, 5'd0, 32'h1000);
    push(K_FLUSH, 5'd0, 32'd2);
    push(K_WB, 5'd5, 32'h44);
    send(32'h000302E7, 32'h40, 32'h1001);
    @(posedge clk); #1;
    chk("jalr_latency", 32'(redir_valid), 32'd1);
    chk("jalr_redir_pc", redir_pc, 32'h1000);
    wait_hi("idle3", 3);

    // misaligned target 0x102
    push(K_MIS, 5'd0, 32'd0);
    send(32'h002000EF, 32'h100, 32'h0);
    @(posedge clk); #1;
    chk("mis_pulse", 32'(misalign_err), 32'd1);
    chk("mis_instr_ready", 32'(instr_ready), 32'd1);
    chk("mis_no_redir", 32'(redir_valid), 32'd0);
    @(posedge clk); #1;
    chk("mis_pulse_end", 32'(misalign_err), 32'd0);
    chk("mis_busy", 32'(busy), 32'd0);

    // backpressure on both handshakes
    redir_ready = 1'b0;
    wb_ready    = 1'b0;
    push(K_REDIR, 5'd0, 32'h308);
    push(K_FLUSH, 5'd0, 32'd2);
    push(K_WB, 5'd1, 32'h304);
    send(32'h008000EF, 32'h300, 32'h0);
    wait_hi("bp_redir", 0);
    repeat (3) begin @(posedge clk); #1; end
    chk("bp_redir_valid", 32'(redir_valid), 32'd1);
    chk("bp_redir_pc", redir_pc, 32'h308);
    redir_ready = 1'b1;
    wait_hi("bp_wb", 2);
    repeat (2) begin @(posedge clk); #1; end
    chk("bp_wb_valid", 32'(wb_valid), 32'd1);
    chk("bp_wb_data", wb_data, 32'h304);
    wb_ready = 1'b1;
    wait_hi("idle5", 3);

    // addi: consumed in one cycle, nothing issued
    send(32'h00000013, 32'h500, 32'h0);
    chk("addi_busy", 32'(busy), 32'd0);
    chk("addi_instr_ready", 32'(instr_ready), 32'd1);
    chk("addi_no_redir", 32'(redir_valid), 32'd0);

    // reset during the second flush cycle aborts the link
    push(K_REDIR, 5'd0, 32'h108);
    push(K_FLUSH, 5'd0, 32'd2);
    send(32'h008000EF, 32'h100, 32'h0);
    wait_hi("flush6", 1);
    @(posedge clk); #1;
    chk("rst6_second_flush", 32'(flush), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst6_flush", 32'(flush), 32'd0);
    chk("rst6_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst6_busy", 32'(busy), 32'd0);
    chk("rst6_redir_valid", 32'(redir_valid), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst6_instr_ready", 32'(instr_ready), 32'd1);
    repeat (10) begin @(posedge clk); #1; end
    chk("rst6_no_wb_later", 32'(wb_valid), 32'd0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
